// File: rtl/upgrade_spawner_pkg.sv
// upgrade_pkg: shared types and constants for the speed-upgrade spawner.
//   state_t          - spawner FSM states
//   LFSR_TAPS        - tap mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   LFSR_DEFAULT_SEED- seed substituted when a zero seed is requested
//   fold_to_range()  - maps a 10-bit raw value into [0, range-1]
package upgrade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COOLDOWN = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  // Bit positions 15,13,12,10 correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // One conditional subtract, then clamp. Not a true modulo: values that
  // still exceed the window after one subtract pile onto the last slot,
  // which is acceptable for pickup placement and keeps the logic shallow.
  function automatic logic [9:0] fold_to_range(input logic [9:0]  raw,
                                               input logic [10:0] range);
    logic [10:0] r;
    r = {1'b0, raw};
    if (r >= range) r = r - range;
    if (r >= range) r = range - 11'd1;
    return r[9:0];
  endfunction

endpackage

// File: rtl/upgrade_spawner_if.sv
// upgrade_spawner_if: pickup bus between the spawner and its neighbours.
//   enable          - game running (to spawner)
//   was_collected   - sticky collected flag from upgrade_speed (to spawner)
//   UpgradeX/Y      - pickup centre position (from spawner)
//   upgrade_visible - pickup drawn / collectable (from spawner)
//   upgrade_hold    - holds upgrade_speed in reset while no pickup is live
//   expired         - one-frame pulse when a pickup times out
//   spawn_count     - saturating spawn counter
interface upgrade_spawner_if;
  logic       enable;
  logic       was_collected;
  logic [9:0] UpgradeX;
  logic [9:0] UpgradeY;
  logic       upgrade_visible;
  logic       upgrade_hold;
  logic       expired;
  logic [7:0] spawn_count;

  modport master (
    input  enable, was_collected,
    output UpgradeX, UpgradeY, upgrade_visible, upgrade_hold, expired, spawn_count
  );

  modport slave (
    output enable, was_collected,
    input  UpgradeX, UpgradeY, upgrade_visible, upgrade_hold, expired, spawn_count
  );
endinterface

// File: rtl/upgrade_spawner_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, advancing on every frame edge.
//   frame_clk - frame clock
//   Reset_n   - asynchronous active-low reset, loads SEED
//   state     - current LFSR value
module lfsr16
  import upgrade_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  output logic [15:0] state
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state <= SEED_EFF;
    else          state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/upgrade_spawner.sv
// upgrade_spawner: places, times and retires the speed-upgrade pickup.
//   frame_clk - frame clock, all state on rising edge
//   Reset_n   - asynchronous active-low reset
//   bus       - upgrade_spawner_if.master: enable/was_collected in;
//               UpgradeX/Y, upgrade_visible, upgrade_hold, expired,
//               spawn_count out (all direct flop outputs)
module upgrade_spawner
  import upgrade_pkg::*;
#(
  parameter int          SPAWN_DELAY = 120,
  parameter int          LIFETIME    = 600,
  parameter int          X_MIN       = 40,
  parameter int          X_MAX       = 599,
  parameter int          Y_MIN       = 40,
  parameter int          Y_MAX       = 439,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              frame_clk,
  input  logic              Reset_n,
  upgrade_spawner_if.master bus
);

  localparam logic [15:0] DELAY_LOAD = 16'(SPAWN_DELAY - 1);
  localparam logic [15:0] LIFE_LOAD  = 16'(LIFETIME - 1);
  localparam logic        LIFE_FINITE = (LIFETIME != 0);
  localparam logic [10:0] X_RANGE    = 11'(X_MAX - X_MIN + 1);
  localparam logic [10:0] Y_RANGE    = 11'(Y_MAX - Y_MIN + 1);
  localparam logic [9:0]  X_BASE     = 10'(X_MIN);
  localparam logic [9:0]  Y_BASE     = 10'(Y_MIN);

  logic [15:0] lfsr;
  state_t      state;
  logic [15:0] counter;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        visible;
  logic        hold;
  logic        expired_q;
  logic [7:0]  spawn_cnt;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .state     (lfsr)
  );

  // visible/hold are kept as their own flops (not decoded from state) so
  // that hold, which feeds an async reset downstream, cannot glitch.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      counter   <= '0;
      pos_x     <= X_BASE;
      pos_y     <= Y_BASE;
      visible   <= 1'b0;
      hold      <= 1'b1;
      expired_q <= 1'b0;
      spawn_cnt <= '0;
    end else begin
      expired_q <= 1'b0;
      if (!bus.enable) begin
        state   <= ST_IDLE;
        counter <= '0;
        visible <= 1'b0;
        hold    <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_COOLDOWN;
            counter <= DELAY_LOAD;
          end
          ST_COOLDOWN: begin
            if (counter != '0) begin
              counter <= counter - 16'd1;
            end else begin
              state   <= ST_ACTIVE;
              counter <= LIFE_LOAD;
              pos_x   <= X_BASE + fold_to_range(lfsr[9:0], X_RANGE);
              pos_y   <= Y_BASE + fold_to_range({lfsr[5:0], lfsr[15:12]}, Y_RANGE);
              visible <= 1'b1;
              hold    <= 1'b0;
              if (spawn_cnt != 8'hFF) spawn_cnt <= spawn_cnt + 8'd1;
            end
          end
          ST_ACTIVE: begin
            // Collection outranks expiry on the same edge.
            if (bus.was_collected) begin
              state   <= ST_COOLDOWN;
              counter <= DELAY_LOAD;
              visible <= 1'b0;
              hold    <= 1'b1;
            end else if (LIFE_FINITE && counter == '0) begin
              state     <= ST_COOLDOWN;
              counter   <= DELAY_LOAD;
              visible   <= 1'b0;
              hold      <= 1'b1;
              expired_q <= 1'b1;
            end else if (LIFE_FINITE) begin
              counter <= counter - 16'd1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            counter <= '0;
            visible <= 1'b0;
            hold    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.UpgradeX        = pos_x;
  assign bus.UpgradeY        = pos_y;
  assign bus.upgrade_visible = visible;
  assign bus.upgrade_hold    = hold;
  assign bus.expired         = expired_q;
  assign bus.spawn_count     = spawn_cnt;

endmodule

// File: tb/tb_upgrade_spawner.sv
// Bench for upgrade_spawner: main instance (SPAWN_DELAY=4, LIFETIME=8) plus two
// mapping instances whose seeds are chosen so the first spawn sees a known LFSR.
module tb_upgrade_spawner;

  logic frame_clk = 1'b0;
  logic Reset_n   = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_vec = 0;
  int n_err = 0;

  // Inverse of one LFSR step, used to pick seeds that step into a target value.
  function automatic logic [15:0] lfsr_prev(input logic [15:0] v);
    return {v[0] ^ v[14] ^ v[13] ^ v[11], v[15:1]};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int fold(input int raw, input int r);
    int v;
    v = raw;
    if (v >= r) v = v - r;
    if (v >= r) v = r - 1;
    return v;
  endfunction

  localparam logic [15:0] SEED_A = lfsr_prev(16'h02BC); // raw X 700, raw Y 960
  localparam logic [15:0] SEED_B = lfsr_prev(16'h0064); // raw X 100, raw Y 576

  upgrade_spawner_if bus();
  upgrade_spawner_if bus_a();
  upgrade_spawner_if bus_b();

  upgrade_spawner #(.SPAWN_DELAY(4), .LIFETIME(8)) dut (
    .frame_clk (frame_clk), .Reset_n (Reset_n), .bus (bus));
  upgrade_spawner #(.SPAWN_DELAY(1), .LIFETIME(0), .LFSR_SEED(SEED_A)) dut_a (
    .frame_clk (frame_clk), .Reset_n (Reset_n), .bus (bus_a));
  upgrade_spawner #(.SPAWN_DELAY(1), .LIFETIME(0), .LFSR_SEED(SEED_B)) dut_b (
    .frame_clk (frame_clk), .Reset_n (Reset_n), .bus (bus_b));

  // Reference LFSR for the main instance.
  logic [15:0] m_lfsr;
  always @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= lfsr_step(m_lfsr);
  end

  typedef struct {
    int x;
    int y;
    int cnt;
  } spawn_t;
  spawn_t sb_q[$];

  // Called just before the spawn edge: the model LFSR then holds the value latched.
  function automatic void sb_push(input int cnt);
    spawn_t e;
    e.x   = 40 + fold(int'(m_lfsr[9:0]), 560);
    e.y   = 40 + fold(int'({m_lfsr[5:0], m_lfsr[15:12]}), 400);
    e.cnt = cnt;
    sb_q.push_back(e);
  endfunction

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic do_reset;
    Reset_n = 1'b0;
    bus.enable = 1'b0;   bus.was_collected = 1'b0;
    bus_a.enable = 1'b0; bus_a.was_collected = 1'b0;
    bus_b.enable = 1'b0; bus_b.was_collected = 1'b0;
    sb_q.delete();
    repeat (2) tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++;
    if ({bus.upgrade_visible, bus.upgrade_hold, bus.expired} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_flags: got vis/hold/exp=%b want 010",
               {bus.upgrade_visible, bus.upgrade_hold, bus.expired});
    end
    n_vec++;
    if (bus.UpgradeX !== 10'd40 || bus.UpgradeY !== 10'd40 || bus.spawn_count !== 8'd0) begin
      n_err++;
      $display("FAIL reset_pos: got x=%0d y=%0d cnt=%0d want x=40 y=40 cnt=0",
               bus.UpgradeX, bus.UpgradeY, bus.spawn_count);
    end
  endtask

  task automatic test_spawn;
    spawn_t e;
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (bus.upgrade_hold !== 1'b1 || bus.upgrade_visible !== 1'b0) begin
        n_err++;
        $display("FAIL cooldown_hold e%0d: got hold=%b vis=%b want hold=1 vis=0",
                 i, bus.upgrade_hold, bus.upgrade_visible);
      end
    end
    sb_push(1);
    tick();
    n_vec++;
    if (bus.upgrade_visible !== 1'b1 || bus.upgrade_hold !== 1'b0) begin
      n_err++;
      $display("FAIL spawn_vis: got vis=%b hold=%b want vis=1 hold=0",
               bus.upgrade_visible, bus.upgrade_hold);
    end
    e = sb_q.pop_front();
    n_vec++;
    if (int'(bus.UpgradeX) != e.x || int'(bus.UpgradeY) != e.y || int'(bus.spawn_count) != e.cnt) begin
      n_err++;
      $display("FAIL spawn_pos1: got x=%0d y=%0d cnt=%0d want x=%0d y=%0d cnt=%0d",
               bus.UpgradeX, bus.UpgradeY, bus.spawn_count, e.x, e.y, e.cnt);
    end
  endtask

  task automatic test_expire;
    spawn_t e;
    for (int i = 5; i <= 11; i++) begin
      tick();
      n_vec++;
      if (bus.upgrade_visible !== 1'b1 || bus.expired !== 1'b0) begin
        n_err++;
        $display("FAIL active_hold e%0d: got vis=%b exp=%b want vis=1 exp=0",
                 i, bus.upgrade_visible, bus.expired);
      end
    end
    tick(); // edge 12
    n_vec++;
    if ({bus.expired, bus.upgrade_visible, bus.upgrade_hold} !== 3'b101) begin
      n_err++;
      $display("FAIL expire_pulse: got exp/vis/hold=%b want 101",
               {bus.expired, bus.upgrade_visible, bus.upgrade_hold});
    end
    tick(); // edge 13
    n_vec++;
    if (bus.expired !== 1'b0) begin
      n_err++;
      $display("FAIL expire_width: got exp=%b want 0", bus.expired);
    end
    tick(); tick(); // edges 14, 15
    sb_push(2);
    tick(); // edge 16
    e = sb_q.pop_front();
    n_vec++;
    if (bus.upgrade_visible !== 1'b1 || int'(bus.UpgradeX) != e.x || int'(bus.UpgradeY) != e.y ||
        int'(bus.spawn_count) != e.cnt) begin
      n_err++;
      $display("FAIL respawn: got vis=%b x=%0d y=%0d cnt=%0d want vis=1 x=%0d y=%0d cnt=%0d",
               bus.upgrade_visible, bus.UpgradeX, bus.UpgradeY, bus.spawn_count, e.x, e.y, e.cnt);
    end
  endtask

  task automatic test_collect;
    spawn_t e;
    do_reset();
    bus.enable = 1'b1;
    repeat (4) tick();
    sb_push(1);
    tick(); // edge 4
    e = sb_q.pop_front();
    tick(); // edge 5
    bus.was_collected = 1'b1;
    tick(); // edge 6
    bus.was_collected = 1'b0;
    n_vec++;
    if ({bus.upgrade_hold, bus.upgrade_visible, bus.expired} !== 3'b100) begin
      n_err++;
      $display("FAIL collect: got hold/vis/exp=%b want 100",
               {bus.upgrade_hold, bus.upgrade_visible, bus.expired});
    end
    repeat (2) tick(); // edges 7, 8
    tick();            // edge 9
    n_vec++;
    if (bus.upgrade_visible !== 1'b0) begin
      n_err++;
      $display("FAIL collect_cooldown: got vis=%b want 0", bus.upgrade_visible);
    end
    sb_push(2);
    tick(); // edge 10
    e = sb_q.pop_front();
    n_vec++;
    if (bus.upgrade_visible !== 1'b1 || int'(bus.UpgradeX) != e.x || int'(bus.UpgradeY) != e.y ||
        int'(bus.spawn_count) != e.cnt) begin
      n_err++;
      $display("FAIL collect_respawn: got vis=%b x=%0d y=%0d cnt=%0d want vis=1 x=%0d y=%0d cnt=%0d",
               bus.upgrade_visible, bus.UpgradeX, bus.UpgradeY, bus.spawn_count, e.x, e.y, e.cnt);
    end
  endtask

  // ACTIVE entered at edge 10; counter reaches 0 for edge 18.
  task automatic test_collect_vs_expiry;
    repeat (7) tick(); // edges 11..17
    bus.was_collected = 1'b1;
    tick(); // edge 18
    bus.was_collected = 1'b0;
    n_vec++;
    if ({bus.upgrade_hold, bus.upgrade_visible, bus.expired} !== 3'b100) begin
      n_err++;
      $display("FAIL collect_wins: got hold/vis/exp=%b want 100",
               {bus.upgrade_hold, bus.upgrade_visible, bus.expired});
    end
    tick(); // edge 19
    n_vec++;
    if (bus.expired !== 1'b0 || bus.spawn_count !== 8'd2) begin
      n_err++;
      $display("FAIL collect_wins_after: got exp=%b cnt=%0d want exp=0 cnt=2",
               bus.expired, bus.spawn_count);
    end
  endtask

  task automatic test_enable_drop;
    spawn_t e;
    tick(); tick(); // edges 20, 21
    sb_push(3);
    tick(); // edge 22
    e = sb_q.pop_front();
    n_vec++;
    if (bus.upgrade_visible !== 1'b1 || int'(bus.UpgradeX) != e.x || int'(bus.UpgradeY) != e.y ||
        int'(bus.spawn_count) != e.cnt) begin
      n_err++;
      $display("FAIL third_spawn: got vis=%b x=%0d y=%0d cnt=%0d want vis=1 x=%0d y=%0d cnt=%0d",
               bus.upgrade_visible, bus.UpgradeX, bus.UpgradeY, bus.spawn_count, e.x, e.y, e.cnt);
    end
    tick();
    bus.enable = 1'b0;
    tick();
    n_vec++;
    if ({bus.upgrade_visible, bus.upgrade_hold, bus.expired} !== 3'b010 || bus.spawn_count !== 8'd3) begin
      n_err++;
      $display("FAIL enable_drop: got vis/hold/exp=%b cnt=%0d want 010 cnt=3",
               {bus.upgrade_visible, bus.upgrade_hold, bus.expired}, bus.spawn_count);
    end
    repeat (6) tick();
    n_vec++;
    if (bus.upgrade_visible !== 1'b0 || bus.upgrade_hold !== 1'b1) begin
      n_err++;
      $display("FAIL idle_stays: got vis=%b hold=%b want vis=0 hold=1",
               bus.upgrade_visible, bus.upgrade_hold);
    end
  endtask

  task automatic test_async_reset;
    spawn_t e;
    bus.enable = 1'b1;
    tick(); tick(); // into COOLDOWN, counter mid-way
    Reset_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.upgrade_visible, bus.upgrade_hold, bus.expired} !== 3'b010 || bus.spawn_count !== 8'd0 ||
        bus.UpgradeX !== 10'd40 || bus.UpgradeY !== 10'd40) begin
      n_err++;
      $display("FAIL async_reset: got vis/hold/exp=%b cnt=%0d x=%0d y=%0d want 010 cnt=0 x=40 y=40",
               {bus.upgrade_visible, bus.upgrade_hold, bus.expired}, bus.spawn_count,
               bus.UpgradeX, bus.UpgradeY);
    end
    #1;
    Reset_n = 1'b1;
    repeat (4) tick();
    sb_push(1);
    tick();
    e = sb_q.pop_front();
    n_vec++;
    if (bus.upgrade_visible !== 1'b1 || int'(bus.UpgradeX) != e.x || int'(bus.UpgradeY) != e.y ||
        int'(bus.spawn_count) != e.cnt) begin
      n_err++;
      $display("FAIL reseed_spawn: got vis=%b x=%0d y=%0d cnt=%0d want vis=1 x=%0d y=%0d cnt=%0d",
               bus.upgrade_visible, bus.UpgradeX, bus.UpgradeY, bus.spawn_count, e.x, e.y, e.cnt);
    end
  endtask

  task automatic test_mapping;
    do_reset();
    bus_a.enable = 1'b1;
    bus_b.enable = 1'b1;
    tick(); // LFSR steps onto target, FSM to COOLDOWN
    tick(); // spawn latches target
    n_vec++;
    if (bus_a.upgrade_visible !== 1'b1 || bus_a.UpgradeX !== 10'd180 || bus_a.UpgradeY !== 10'd439) begin
      n_err++;
      $display("FAIL map_fold_clamp: got vis=%b x=%0d y=%0d want vis=1 x=180 y=439",
               bus_a.upgrade_visible, bus_a.UpgradeX, bus_a.UpgradeY);
    end
    n_vec++;
    if (bus_b.upgrade_visible !== 1'b1 || bus_b.UpgradeX !== 10'd140 || bus_b.UpgradeY !== 10'd216) begin
      n_err++;
      $display("FAIL map_inrange: got vis=%b x=%0d y=%0d want vis=1 x=140 y=216",
               bus_b.upgrade_visible, bus_b.UpgradeX, bus_b.UpgradeY);
    end
    repeat (20) tick();
    n_vec++;
    if (bus_a.upgrade_visible !== 1'b1 || bus_a.expired !== 1'b0 || bus_a.spawn_count !== 8'd1) begin
      n_err++;
      $display("FAIL no_expiry: got vis=%b exp=%b cnt=%0d want vis=1 exp=0 cnt=1",
               bus_a.upgrade_visible, bus_a.expired, bus_a.spawn_count);
    end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_expire();
    test_collect();
    test_collect_vs_expiry();
    test_enable_drop();
    test_async_reset();
    test_mapping();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
